dcache_mem_responder: RTL and testbench

Memory-side responder for the Dcache mem port. It accepts one request at a time (cached line read, uncached single-word read, or strobed word write) from the Dcache mem-port signals. It serves each request from an internal word-wide memory array and returns addrOK/dataOK handshakes. The block sits below the L1 Dcache as its backing memory for simulation and FPGA bring-up.

---
 rtl/dcache_mem_pkg.sv | 24 ++
 rtl/dcache_mem_array.sv | 26 ++
 rtl/dcache_mem_responder.sv | 121 ++++++++++++
 tb/tb_dcache_mem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dcache_mem_pkg.sv
// Shared types and helpers for the Dcache backing-memory responder.
// The WAIT state only exists when DMEM_RESP_WAIT_EN is defined.
package dcache_mem_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StAck  = 3'd1,
      StRd   = 3'd2,
      StWr   = 3'd3,
`ifdef DMEM_RESP_WAIT_EN
      StWait = 3'd5,
`endif
      StResp = 3'd4
   } state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   function automatic int unsigned line_width(input int unsigned offset_width);
      return 32 * (1 << offset_width);
   endfunction

endpackage

// File: rtl/dcache_mem_array.sv
// Word-wide storage: synchronous byte-enabled write, combinational read.
// Contents are never reset.
module dcache_mem_array #(
   parameter int unsigned addr_width = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [3:0]            wstrb,
   input  logic [addr_width-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(1 << addr_width)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the Dcache mem port: one request at a time, served from a
// word-wide array. Define DMEM_RESP_WAIT_EN to insert wait_cycles of latency after addrOK.
module dcache_mem_responder
   import dcache_mem_pkg::*;
#(
   parameter int unsigned offset_width   = 2,
   parameter int unsigned mem_addr_width = 10,
   parameter int unsigned wait_cycles    = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [31:0]                          addr_dcache_mem,
   input  logic [31:0]                          dout_dcache_mem,
   output logic [line_width(offset_width)-1:0]  din_mem_dcache,
   input  logic                                 dcache_mem_req,
   input  logic                                 dcache_mem_wr,
   input  logic                                 dcache_mem_SUC,
   input  logic [1:0]                           dcache_mem_size,
   input  logic [3:0]                           dcache_mem_wstrb,
   output logic                                 mem_dcache_addrOK,
   output logic                                 mem_dcache_dataOK
);

   localparam int unsigned LineW = line_width(offset_width);
   localparam int unsigned Beats = 1 << offset_width;

   state_e                    state_q, state_d;
   logic [31:0]               addr_q, wdata_q;
   logic                      wr_q, suc_q;
   logic [3:0]                wstrb_q;
   logic [offset_width-1:0]   beat_q;
   logic [LineW-1:0]          line_q;
   logic [mem_addr_width-1:0] word_idx, line_idx, mem_addr;
   logic [31:0]               mem_rdata;
   logic                      mem_we, last_beat, accept;

   assign accept    = (state_q == StIdle) && dcache_mem_req;
   // Index wraps modulo the array; cached reads walk the whole aligned line.
   assign word_idx  = addr_q[mem_addr_width+1:2];
   assign line_idx  = {word_idx[mem_addr_width-1:offset_width], beat_q};
   assign mem_addr  = (suc_q || wr_q) ? word_idx : line_idx;
   assign last_beat = suc_q || (beat_q == offset_width'(Beats - 1));
   assign mem_we    = (state_q == StWr) && !rst;

`ifdef DMEM_RESP_WAIT_EN
   logic [31:0] wait_q;

   // Counts down from acceptance so that WAIT lasts max(wait_cycles, 1) cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q <= '0;
      end else if (accept) begin
         wait_q <= 32'(wait_cycles);
      end else if (wait_q != '0) begin
         wait_q <= wait_q - 32'd1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (dcache_mem_req) state_d = StAck;
`ifdef DMEM_RESP_WAIT_EN
         StAck:  state_d = StWait;
         StWait: if (wait_q == '0) state_d = wr_q ? StWr : StRd;
`else
         StAck:  state_d = wr_q ? StWr : StRd;
`endif
         StRd:   if (last_beat) state_d = StResp;
         StWr:   state_d = StResp;
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StRd) begin
            if (suc_q) line_q <= {{(LineW - 32){1'b0}}, mem_rdata};
            else       line_q[32*beat_q +: 32] <= mem_rdata;
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= addr_dcache_mem;
         wdata_q <= dout_dcache_mem;
         wr_q    <= dcache_mem_wr;
         suc_q   <= dcache_mem_SUC;
         wstrb_q <= dcache_mem_wstrb;
      end
   end

   dcache_mem_array #(
      .addr_width(mem_addr_width)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .wstrb(wstrb_q),
      .addr (mem_addr),
      .wdata(wdata_q),
      .rdata(mem_rdata)
   );

   assign mem_dcache_addrOK = (state_q == StAck);
   assign mem_dcache_dataOK = (state_q == StResp);
   assign din_mem_dcache    = line_q;

   // Size is informational only; high address bits alias.
   logic unused_bits;
   assign unused_bits = ^{dcache_mem_size, addr_q[31:mem_addr_width+2], addr_q[1:0]};

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed, table-driven bench for dcache_mem_responder (default parameters).
// Expected latencies shift by wait_cycles when DMEM_RESP_WAIT_EN is defined.
module tb_dcache_mem_responder;

`ifdef DMEM_RESP_WAIT_EN
   localparam int Extra = 3;
`else
   localparam int Extra = 0;
`endif
   localparam int WrOk = 3 + Extra;
   localparam int UcOk = 3 + Extra;
   localparam int CaOk = 6 + Extra;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  addr = '0, wdata = '0;
   logic [127:0] din;
   logic         req = 1'b0, wr = 1'b0, suc = 1'b0;
   logic [1:0]   size = 2'd2;
   logic [3:0]   wstrb = 4'h0;
   logic         addr_ok, data_ok;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   dcache_mem_responder #(
      .offset_width  (2),
      .mem_addr_width(10),
      .wait_cycles   (3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .addr_dcache_mem  (addr),
      .dout_dcache_mem  (wdata),
      .din_mem_dcache   (din),
      .dcache_mem_req   (req),
      .dcache_mem_wr    (wr),
      .dcache_mem_SUC   (suc),
      .dcache_mem_size  (size),
      .dcache_mem_wstrb (wstrb),
      .mem_dcache_addrOK(addr_ok),
      .mem_dcache_dataOK(data_ok)
   );

   typedef struct {
      logic [31:0]  addr;
      logic         wr;
      logic         suc;
      logic [3:0]   wstrb;
      logic [31:0]  wdata;
      int           exp_ok;
      logic [127:0] exp_line;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   // Cycle 0 is the IDLE cycle with req high; inputs change and outputs sample on negedge.
   task automatic run_req(input logic [31:0] a, input logic w, input logic s,
                          input logic [3:0] st, input logic [31:0] d,
                          output int ack_c, output int ok_c);
      @(negedge clk);
      addr = a; wr = w; suc = s; wstrb = st; wdata = d; req = 1'b1;
      ack_c = -1;
      ok_c  = -1;
      for (int c = 1; c <= 40 && ok_c < 0; c++) begin
         @(negedge clk);
         if (addr_ok) begin
            if (ack_c < 0) ack_c = c;
            req = 1'b0;
         end
         if (data_ok) ok_c = c;
      end
      req = 1'b0;
   endtask

   initial begin
      int ack_c, ok_c, bad;
      logic [127:0] l1, l2, l3, l4;
      l1 = 128'h000000A3_000000A2_000000A1_000000A0;
      l2 = {96'h0, 32'h11AD11EF};
      l3 = {96'h0, 32'h00000055};
      l4 = 128'h000000A3_000000A2_11AD11EF_000000A0;

      vecs[0]  = '{32'h40,   1'b1, 1'b0, 4'hF, 32'hA0,       WrOk, '0};
      vecs[1]  = '{32'h44,   1'b1, 1'b0, 4'hF, 32'hA1,       WrOk, '0};
      vecs[2]  = '{32'h48,   1'b1, 1'b0, 4'hF, 32'hA2,       WrOk, '0};
      vecs[3]  = '{32'h4C,   1'b1, 1'b0, 4'hF, 32'hA3,       WrOk, '0};
      vecs[4]  = '{32'h48,   1'b0, 1'b0, 4'h0, 32'h0,        CaOk, l1};
      vecs[5]  = '{32'h44,   1'b1, 1'b0, 4'hF, 32'h11111111, WrOk, l1};
      vecs[6]  = '{32'h44,   1'b1, 1'b0, 4'h5, 32'hDEADBEEF, WrOk, l1};
      vecs[7]  = '{32'h44,   1'b0, 1'b1, 4'h0, 32'h0,        UcOk, l2};
      vecs[8]  = '{32'h1000, 1'b1, 1'b0, 4'hF, 32'h55,       WrOk, l2};
      vecs[9]  = '{32'h0,    1'b0, 1'b1, 4'h0, 32'h0,        UcOk, l3};
      vecs[10] = '{32'h48,   1'b1, 1'b0, 4'h0, 32'hFFFFFFFF, WrOk, l3};
      vecs[11] = '{32'h4C,   1'b0, 1'b0, 4'h0, 32'h0,        CaOk, l4};
      vecs[12] = '{32'h80,   1'b1, 1'b0, 4'hF, 32'h12345678, WrOk, l4};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_handshakes", {126'h0, addr_ok, data_ok}, '0);
         check("idle_din", din, '0);
      end

      for (int i = 0; i < 13; i++) begin
         run_req(vecs[i].addr, vecs[i].wr, vecs[i].suc, vecs[i].wstrb, vecs[i].wdata,
                 ack_c, ok_c);
         check($sformatf("vec%0d_addrok_cycle", i), 128'(ack_c), 128'(1));
         check($sformatf("vec%0d_dataok_cycle", i), 128'(ok_c), 128'(vecs[i].exp_ok));
         check($sformatf("vec%0d_line", i), din, vecs[i].exp_line);
      end

      // Reset while the write to 0x80 is in WR: write suppressed, no dataOK.
      @(negedge clk);
      addr = 32'h80; wr = 1'b1; suc = 1'b0; wstrb = 4'hF; wdata = 32'hCAFEF00D; req = 1'b1;
      @(negedge clk);
      check("abort_addrok", {127'h0, addr_ok}, 128'h1);
      req = 1'b0;
      repeat (Extra + 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         if (data_ok !== 1'b0 || addr_ok !== 1'b0) bad++;
         @(negedge clk);
      end
      check("abort_no_handshake", 128'(bad), '0);
      check("abort_din_reset", din, '0);

      run_req(32'h80, 1'b0, 1'b1, 4'h0, 32'h0, ack_c, ok_c);
      check("post_abort_addrok_cycle", 128'(ack_c), 128'(1));
      check("post_abort_dataok_cycle", 128'(ok_c), 128'(UcOk));
      check("post_abort_word", din, {96'h0, 32'h12345678});

      // Back-to-back: next request accepted in the IDLE cycle right after RESP.
      run_req(32'h40, 1'b0, 1'b0, 4'h0, 32'h0, ack_c, ok_c);
      check("b2b_addrok_cycle", 128'(ack_c), 128'(1));
      check("b2b_dataok_cycle", 128'(ok_c), 128'(CaOk));
      check("b2b_line", din, l4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
